// File: rtl/melody_sequencer.sv
// melody_sequencer: FIFO-fed note scheduler driving the beep generator tone select.
// The CPU queues (pitch, duration) entries; the sequencer plays each pitch for
// duration*TICK_CYCLES cycles, followed by GAP_TICKS*TICK_CYCLES silent cycles.
//
// Optional feature: define SEQ_LOOP_EN to build the re-queue path. With it,
// loop=1 writes every popped entry back to the FIFO tail so the sequence repeats.
//
// Ports:
//   clk        in   system clock (62.5 MHz domain)
//   reset      in   synchronous, active-high
//   push       in   strobe: enqueue push_data ([7:0] pitch, [15:8] duration ticks)
//   push_data  in   16-bit entry
//   flush      in   strobe: empty FIFO, clear overflow, stop playback
//   start      in   strobe: begin playback (ignored when empty or playing)
//   stop       in   strobe: abort playback, keep queued entries
//   loop       in   level: re-queue played entries (SEQ_LOOP_EN builds only)
//   mode       out  tone select, nonzero only while a note sounds
//   playing    out  high whenever the sequencer is not idle
//   full/empty out  FIFO occupancy flags
//   level      out  FIFO occupancy
//   overflow   out  sticky: a push was dropped on a full FIFO
//   done       out  one-cycle pulse when playback drains the FIFO
module melody_sequencer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TICK_CYCLES = 625000,
    parameter int unsigned GAP_TICKS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [15:0]                push_data,
    input  logic                       flush,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    output logic [7:0]                 mode,
    output logic                       playing,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned RW = 16;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_CYCLES - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [RW-1:0] GAP_LOAD   = RW'(GAP_TICKS);
    localparam bit            HAS_GAP    = (GAP_TICKS != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_NOTE,
        S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [15:0]     mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [RW-1:0]   remaining_q, remaining_d;
    logic [7:0]      mode_q, mode_d;
    logic            playing_q, playing_d;
    logic            done_q, done_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;

    logic [15:0]     head_c;
    logic [7:0]      head_pitch_c;
    logic [7:0]      head_dur_c;
    logic            pop_c;
    logic            requeue_c;
    logic            space_c;
    logic            push_ok_c;
    logic            more_c;
    logic            tick_wrap_c;
    logic [AW-1:0]   push_slot_c;

    assign head_c       = mem_q[rd_ptr_q];
    assign head_pitch_c = head_c[7:0];
    assign head_dur_c   = head_c[15:8];

    // A pop only happens in LOAD and is cancelled by stop/flush so entries are retained.
    assign pop_c = (state_q == S_LOAD) && (level_q != '0) && !stop && !flush;

`ifdef SEQ_LOOP_EN
    assign requeue_c = pop_c && loop;
`else
    logic unused_loop_c;
    assign unused_loop_c = loop;
    assign requeue_c     = 1'b0;
`endif

    // A plain pop frees a slot for a same-cycle push; a re-queue consumes it again.
    assign space_c     = (level_q != LEVEL_FULL) || (pop_c && !requeue_c);
    assign push_ok_c   = push && !flush && space_c;
    assign push_slot_c = wr_ptr_q + AW'(requeue_c);
    assign tick_wrap_c = (presc_q == PRESC_MAX);
    // Entries still available after this LOAD's pop (a same-cycle push counts).
    assign more_c      = (level_q > LW'(1)) || push_ok_c || requeue_c;

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push && !space_c) begin
                overflow_d = 1'b1;
            end
`ifdef SEQ_LOOP_EN
            if (requeue_c) begin
                mem_d[wr_ptr_q] = head_c;
            end
`endif
            if (push_ok_c) begin
                mem_d[push_slot_c] = push_data;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            wr_ptr_d = wr_ptr_q + AW'(requeue_c) + AW'(push_ok_c);
            level_d  = level_q + LW'(requeue_c) + LW'(push_ok_c) - LW'(pop_c);
        end
    end

    // Playback FSM: next state, tick prescaler, remaining-tick counter, outputs.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        mode_d      = 8'd0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (level_q != '0)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (level_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (head_dur_c == 8'd0) begin
                    if (more_c) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d     = S_NOTE;
                    remaining_d = RW'(head_dur_c);
                    presc_d     = '0;
                    mode_d      = head_pitch_c;
                end
            end
            S_NOTE: begin
                mode_d = mode_q;
                if (tick_wrap_c) begin
                    presc_d     = '0;
                    remaining_d = remaining_q - RW'(1);
                    if (remaining_q == RW'(1)) begin
                        mode_d = 8'd0;
                        if (HAS_GAP) begin
                            state_d     = S_GAP;
                            remaining_d = GAP_LOAD;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_GAP: begin
                if (tick_wrap_c) begin
                    presc_d     = '0;
                    remaining_d = remaining_q - RW'(1);
                    if (remaining_q == RW'(1)) begin
                        state_d = S_LOAD;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // stop and flush abort playback from any state and beat start.
        if (stop || flush) begin
            state_d = S_IDLE;
            mode_d  = 8'd0;
            done_d  = 1'b0;
        end
    end

    assign playing_d = (state_d != S_IDLE);
    assign full_d    = (level_d == LEVEL_FULL);
    assign empty_d   = (level_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            presc_q     <= '0;
            remaining_q <= '0;
            mode_q      <= 8'd0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            playing_q   <= playing_d;
            done_q      <= done_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    assign mode     = mode_q;
    assign playing  = playing_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with DEPTH=4, TICK_CYCLES=4, GAP_TICKS=1.
// Expected per-cycle {mode, playing, done, level} are queued when a playback is
// started and popped against the DUT one cycle at a time.
module tb_melody_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TICK  = 4;
    localparam int unsigned GAP   = 1;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [15:0]   push_data;
    logic          flush;
    logic          start;
    logic          stop;
    logic          loop;
    logic [7:0]    mode;
    logic          playing;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          done;

    always #5 clk = ~clk;

    melody_sequencer #(
        .DEPTH       (DEPTH),
        .TICK_CYCLES (TICK),
        .GAP_TICKS   (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .flush     (flush),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .mode      (mode),
        .playing   (playing),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .done      (done)
    );

    typedef struct packed {
        logic [7:0]    mode;
        logic          playing;
        logic          done;
        logic [LW-1:0] level;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_n(input logic [7:0] m, input logic p, input logic d,
                            input logic [LW-1:0] l, input int n);
        exp_t e;
        e.mode    = m;
        e.playing = p;
        e.done    = d;
        e.level   = l;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    // One note: LOAD cycle, the note itself, then the gap.
    task automatic expect_note(input logic [7:0] pitch, input int dur,
                               input logic [LW-1:0] lvl_load, input logic [LW-1:0] lvl_after);
        expect_n(8'd0, 1'b1, 1'b0, lvl_load, 1);
        expect_n(pitch, 1'b1, 1'b0, lvl_after, dur * TICK);
        expect_n(8'd0, 1'b1, 1'b0, lvl_after, GAP * TICK);
    endtask

    task automatic expect_drain();
        expect_n(8'd0, 1'b1, 1'b0, '0, 1);
        expect_n(8'd0, 1'b0, 1'b1, '0, 1);
        expect_n(8'd0, 1'b0, 1'b0, '0, 1);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        int   idx;
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("%s[%0d].mode", tag, idx), 16'(mode), 16'(e.mode));
            chk($sformatf("%s[%0d].playing", tag, idx), 16'(playing), 16'(e.playing));
            chk($sformatf("%s[%0d].done", tag, idx), 16'(done), 16'(e.done));
            chk($sformatf("%s[%0d].level", tag, idx), 16'(level), 16'(e.level));
            idx++;
            tick();
        end
    endtask

    task automatic push_entry(input logic [7:0] dur, input logic [7:0] pitch);
        push      = 1'b1;
        push_data = {dur, pitch};
        tick();
        push      = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".mode"}, 16'(mode), 16'd0);
        chk({tag, ".playing"}, 16'(playing), 16'd0);
        chk({tag, ".overflow"}, 16'(overflow), 16'd0);
        chk({tag, ".done"}, 16'(done), 16'd0);
        chk({tag, ".level"}, 16'(level), 16'd0);
        chk({tag, ".empty"}, 16'(empty), 16'd1);
        chk({tag, ".full"}, 16'(full), 16'd0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; push_data = '0; flush = 1'b0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        // Two notes with a gap after each, then done once and empty.
        push_entry(8'd2, 8'd5);
        push_entry(8'd1, 8'd10);
        chk("t1.level", 16'(level), 16'd2);
        chk("t1.empty", 16'(empty), 16'd0);
        do_start();
        expect_note(8'd5, 2, 3'd2, 3'd1);
        expect_note(8'd10, 1, 3'd1, 3'd0);
        expect_drain();
        drain("t1");
        chk("t1.empty_end", 16'(empty), 16'd1);

        // Start on an empty FIFO is ignored.
        do_start();
        chk("start_empty.playing", 16'(playing), 16'd0);
        chk("start_empty.done", 16'(done), 16'd0);
        tick();
        chk("start_empty.done2", 16'(done), 16'd0);

        // Overflow on the fifth push, flush clears it.
        for (int i = 0; i < 4; i++) push_entry(8'd1, 8'(i + 1));
        chk("t2.full", 16'(full), 16'd1);
        chk("t2.level4", 16'(level), 16'd4);
        chk("t2.ovf_before", 16'(overflow), 16'd0);
        push_entry(8'd1, 8'd99);
        chk("t2.overflow", 16'(overflow), 16'd1);
        chk("t2.level_after", 16'(level), 16'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t2.flush_level", 16'(level), 16'd0);
        chk("t2.flush_ovf", 16'(overflow), 16'd0);
        chk("t2.flush_empty", 16'(empty), 16'd1);
        chk("t2.flush_full", 16'(full), 16'd0);

        // Flush beats a same-cycle push without flagging overflow.
        push = 1'b1; flush = 1'b1; push_data = {8'd1, 8'd20};
        tick();
        push = 1'b0; flush = 1'b0;
        chk("flush_push.level", 16'(level), 16'd0);
        chk("flush_push.ovf", 16'(overflow), 16'd0);

        // Zero-duration entry is skipped silently.
`ifndef SEQ_LOOP_EN
        loop = 1'b1;
`endif
        push_entry(8'd0, 8'd3);
        push_entry(8'd1, 8'd7);
        do_start();
        expect_n(8'd0, 1'b1, 1'b0, 3'd2, 1);
        expect_note(8'd7, 1, 3'd1, 3'd0);
        expect_drain();
        drain("t3");
        loop = 1'b0;

        // Stop mid-note keeps the queue; stop beats start; restart resumes.
        push_entry(8'd3, 8'd9);
        push_entry(8'd1, 8'd1);
        push_entry(8'd1, 8'd2);
        do_start();
        expect_n(8'd0, 1'b1, 1'b0, 3'd3, 1);
        expect_n(8'd9, 1'b1, 1'b0, 3'd2, 1);
        drain("t4a");
        chk("t4.mode_note", 16'(mode), 16'd9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4.stop_mode", 16'(mode), 16'd0);
        chk("t4.stop_playing", 16'(playing), 16'd0);
        chk("t4.stop_level", 16'(level), 16'd2);
        chk("t4.stop_done", 16'(done), 16'd0);
        tick();
        chk("t4.stop_done2", 16'(done), 16'd0);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("t4.stop_start", 16'(playing), 16'd0);
        do_start();
        expect_note(8'd1, 1, 3'd2, 3'd1);
        expect_note(8'd2, 1, 3'd1, 3'd0);
        expect_drain();
        drain("t4b");

        // Push with pop at full is accepted; push at full without pop overflows.
        for (int i = 0; i < 4; i++) push_entry(8'd1, 8'(11 + i));
        chk("t5.full", 16'(full), 16'd1);
        do_start();
        chk("t5.load_level", 16'(level), 16'd4);
        push = 1'b1; push_data = {8'd1, 8'd15};
        tick();
        push = 1'b0;
        chk("t5.pp_level", 16'(level), 16'd4);
        chk("t5.pp_ovf", 16'(overflow), 16'd0);
        chk("t5.pp_mode", 16'(mode), 16'd11);
        push = 1'b1; push_data = {8'd1, 8'd16};
        tick();
        push = 1'b0;
        chk("t5.full_ovf", 16'(overflow), 16'd1);
        chk("t5.full_level", 16'(level), 16'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5.flush_playing", 16'(playing), 16'd0);
        chk("t5.flush_mode", 16'(mode), 16'd0);
        chk("t5.flush_level", 16'(level), 16'd0);
        chk("t5.flush_ovf", 16'(overflow), 16'd0);
        tick();
        chk("t5.flush_done", 16'(done), 16'd0);

`ifdef SEQ_LOOP_EN
        // Loop repeats the sequence with level steady, then drains once.
        loop = 1'b1;
        push_entry(8'd1, 8'd4);
        push_entry(8'd1, 8'd6);
        do_start();
        for (int r = 0; r < 3; r++) begin
            expect_note(8'd4, 1, 3'd2, 3'd2);
            expect_note(8'd6, 1, 3'd2, 3'd2);
        end
        drain("t6a");
        loop = 1'b0;
        expect_note(8'd4, 1, 3'd2, 3'd1);
        expect_note(8'd6, 1, 3'd1, 3'd0);
        expect_drain();
        drain("t6b");
`endif

        // Reset in the middle of a note.
        push_entry(8'd2, 8'd8);
        do_start();
        tick();
        tick();
        chk("rst_mid.mode_before", 16'(mode), 16'd8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Autonomous note scheduler that drives the 8-bit tone-select `mode` input of the beep tone generator. The CPU pushes (pitch, duration) entries into an internal FIFO through memory-mapped strobes. The sequencer plays them back with exact tick-based durations and an optional silent gap between notes, so software no longer times each note itself. It sits in the CPU clock domain (62.5 MHz) beside the tone generator; its `mode` output replaces the CPU-written mode register.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)
TICK_CYCLES, 625000, clock cycles per duration tick (10 ms at 62.5 MHz)
GAP_TICKS, 1, silent ticks inserted after each note (0 = none)

Ports:
clk  in  1  system clock (62.5 MHz domain)
reset  in  1  synchronous, active-high
push  in  1  one-cycle strobe: enqueue push_data
push_data  in  16  [7:0] pitch code (0 = rest), [15:8] duration in ticks
flush  in  1  one-cycle strobe: empty FIFO, clear overflow
start  in  1  one-cycle strobe: begin playback
stop  in  1  one-cycle strobe: abort playback
loop  in  1  level: re-queue played notes (effective only with SEQ_LOOP_EN)
mode  out  8  tone select to beep generator
playing  out  1  high whenever state != IDLE
full  out  1  level == DEPTH
empty  out  1  level == 0
level  out  clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a push was dropped because the FIFO was full
done  out  1  one-cycle pulse when playback drains the FIFO

Behaviour:
- Reset: FIFO empty, state IDLE; mode=0, playing=0, overflow=0, done=0, level=0, empty=1, full=0.
- FIFO: push when not full stores the entry at the tail and level increments next cycle. Push when full is dropped and overflow is set. Simultaneous push and pop leaves level unchanged. A push to an empty FIFO is not poppable until the following cycle.
- States: IDLE, LOAD, NOTE, GAP.
- IDLE: mode=0. A start with empty=0 moves to LOAD. A start with empty=1 is ignored and does not pulse done.
- LOAD (1 cycle): pop the head entry.
  - If duration=0, the entry is discarded: go back to LOAD if more entries remain, otherwise go to IDLE and pulse done.
  - Otherwise load remaining=duration, clear the tick prescaler and go to NOTE.
  - If the FIFO is empty at LOAD, go to IDLE and pulse done.
- NOTE: mode=pitch for exactly duration*TICK_CYCLES cycles. The prescaler counts 0..TICK_CYCLES-1; each wrap decrements remaining. When remaining reaches 0, go to GAP (GAP_TICKS>0) or LOAD (GAP_TICKS=0).
- GAP: mode=0 for exactly GAP_TICKS*TICK_CYCLES cycles, then LOAD.
- mode is registered and is nonzero only in NOTE. A rest entry (pitch 0) therefore holds mode=0 for its full duration.
- stop, in any state: next state is IDLE and mode=0 next cycle. The current note is abandoned, remaining FIFO entries are retained and done is not pulsed.
- stop and start in the same cycle: stop wins.
- flush: clears the FIFO (level=0, overflow=0) next cycle. If playing, the state also goes to IDLE as for stop. Flush and push in the same cycle: flush wins and the push is dropped without setting overflow.
- start while playing: ignored.
- Pushes during playback are accepted and played in order.
- reset mid-note: all state returns to reset values on the next edge.

Optional Feature:
Macro SEQ_LOOP_EN.
- Defined: when loop=1, each entry popped in LOAD (including duration-0 entries) is written back to the FIFO tail in the same cycle. Level is unchanged, playback repeats the sequence indefinitely and done never pulses while loop=1. A CPU push coinciding with a re-queue onto a FIFO that was full before the pop is dropped and sets overflow; the re-queue has priority.
- Not defined: the loop input is ignored, no re-queue logic is built and popped entries are consumed.

Test Plan:
1. TICK_CYCLES=4, GAP_TICKS=1, DEPTH=4. Push {dur=2,pitch=5} and {dur=1,pitch=10}, then start. Required: mode=5 for 8 cycles, 0 for 4, 10 for 4, 0 for 4; then IDLE with done pulsing exactly once and empty=1.
2. Push 5 entries into DEPTH=4 -> full=1 after the 4th push, 5th dropped, overflow=1, level=4. A following flush -> level=0, overflow=0.
3. Queue {dur=0,pitch=3} then {dur=1,pitch=7}, start -> pitch 3 never appears on mode; mode=7 for exactly 4 cycles.
4. stop asserted 2 cycles into a 3-tick note with 2 entries queued behind it -> mode=0 next cycle, playing=0, level=2, no done. A new start resumes from the next entry.
5. Simultaneous push and pop in LOAD with level=4, DEPTH=4 -> push accepted, level stays 4, overflow stays 0. A push to a FIFO that is full with no pop in that cycle -> dropped, overflow=1.
6. SEQ_LOOP_EN defined, loop=1, 2 entries, start -> sequence repeats at least 3 times, level stays 2, done never pulses. Deassert loop -> remaining entries play once, then done.
